// File: rtl/prim_generic_ram_1p_pipe.sv
// Generic single-port SRAM model: grant/valid handshake, grouped write mask,
// optional extra read-data register stage and optional zero-fill after reset.
//
// state | meaning
// INIT  | clearing word init_cnt_q to zero, requests not granted
// READY | memory usable, every request granted
module prim_generic_ram_1p_pipe #(
   parameter int Width           = 32,
   parameter int Depth           = 128,
   parameter int DataBitsPerMask = 1,
   parameter int OutputReg       = 0,
   parameter int ZeroInit        = 1,
   localparam int Aw             = (Depth > 1) ? $clog2(Depth) : 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             req_i,
   output logic             gnt_o,
   input  logic             write_i,
   input  logic [Aw-1:0]    addr_i,
   input  logic [Width-1:0] wdata_i,
   input  logic [Width-1:0] wmask_i,
   output logic             rvalid_o,
   output logic [Width-1:0] rdata_o,
   output logic             rerr_o,
   output logic             init_done_o
);

   localparam int            NumGroups = Width / DataBitsPerMask;
   localparam logic [Aw:0]   DepthW    = (Aw+1)'(Depth);
   localparam logic [Aw-1:0] LastAddr  = Aw'(Depth - 1);

   if (Width % DataBitsPerMask != 0) begin : g_bad_mask_width
      $error("Width must be a multiple of DataBitsPerMask");
   end

   typedef enum logic {INIT, READY} state_e;

   state_e                 state_q, state_d;
   logic [Aw-1:0]          init_cnt_q;
   logic [Width-1:0]       mem [Depth];

   logic                   in_range, acc_rd, acc_wr, mem_we, mask_ok;
   logic [Aw-1:0]          mem_addr;
   logic [Width-1:0]       mem_wdata;
   logic [NumGroups-1:0]   grp_on, mem_be;
   logic                   rvalid_q, rerr_q;
   logic [Width-1:0]       rdata_q;

   assign in_range = {1'b0, addr_i} < DepthW;

   // Outputs are gated by reset so nothing is granted while rst_ni is low.
   always_comb begin
      state_d     = state_q;
      gnt_o       = 1'b0;
      init_done_o = 1'b0;
      case (state_q)
         INIT: begin
            if (init_cnt_q == LastAddr) state_d = READY;
         end
         READY: begin
            gnt_o       = rst_ni;
            init_done_o = rst_ni;
         end
      endcase
   end

   assign acc_rd = req_i & gnt_o & ~write_i;
   assign acc_wr = req_i & gnt_o & write_i & in_range;

   always_comb begin
      grp_on  = '0;
      mask_ok = 1'b1;
      for (int k = 0; k < NumGroups; k++) begin
         grp_on[k] = &wmask_i[k*DataBitsPerMask +: DataBitsPerMask];
         if ((|wmask_i[k*DataBitsPerMask +: DataBitsPerMask]) && !grp_on[k]) mask_ok = 1'b0;
      end
   end

   assign mem_we    = rst_ni & ((state_q == INIT) | acc_wr);
   assign mem_addr  = (state_q == INIT) ? init_cnt_q : addr_i;
   assign mem_wdata = (state_q == INIT) ? '0 : wdata_i;
   assign mem_be    = (state_q == INIT) ? '1 : grp_on;

   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int k = 0; k < NumGroups; k++) begin
            if (mem_be[k]) begin
               mem[mem_addr][k*DataBitsPerMask +: DataBitsPerMask] <=
                  mem_wdata[k*DataBitsPerMask +: DataBitsPerMask];
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= (ZeroInit != 0) ? INIT : READY;
         init_cnt_q <= '0;
         rvalid_q   <= 1'b0;
         rerr_q     <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == INIT && init_cnt_q != LastAddr) init_cnt_q <= init_cnt_q + Aw'(1);
         rvalid_q <= acc_rd;
         rerr_q   <= acc_rd & ~in_range;
         if (acc_rd) rdata_q <= in_range ? mem[addr_i] : '0;
      end
   end

   if (OutputReg != 0) begin : g_out_reg
      logic             rvalid_q2, rerr_q2;
      logic [Width-1:0] rdata_q2;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            rvalid_q2 <= 1'b0;
            rerr_q2   <= 1'b0;
            rdata_q2  <= '0;
         end else begin
            rvalid_q2 <= rvalid_q;
            rerr_q2   <= rerr_q;
            if (rvalid_q) rdata_q2 <= rdata_q;
         end
      end

      assign rvalid_o = rvalid_q2;
      assign rerr_o   = rerr_q2;
      assign rdata_o  = rdata_q2;
   end else begin : g_no_out_reg
      assign rvalid_o = rvalid_q;
      assign rerr_o   = rerr_q;
      assign rdata_o  = rdata_q;
   end

   // Partial groups cannot be expressed by the byte-enable style write port.
   mask_groups_uniform: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (req_i && write_i) |-> mask_ok);

endmodule
